// File: rtl/panda_icb_sram_slave.sv
// ---------------------------------------------------------------------------
// panda_icb_sram_slave
//
// Purpose: single-ported SRAM behind an ICB-style command/response slave.
//   Each accepted command touches the memory array on its acceptance edge.
//   Its response is queued in a small in-order FIFO. Out-of-range or
//   misaligned accesses never touch memory. They return a zero-data response
//   with the error flag set.
//
// Parameters:
//   ADDR_WIDTH  command byte-address width
//   DATA_WIDTH  data width (8/16/32/64)
//   MEM_DEPTH   number of DATA_WIDTH-bit words in the array
//   RSP_DEPTH   response FIFO entries (>= 1)
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset (memory array is not reset)
//   cmd_addr_i   byte address of the command
//   cmd_read_i   1 = read, 0 = write
//   cmd_wdata_i  write data
//   cmd_wmask_i  per-byte write enables
//   cmd_valid_i  command valid
//   cmd_ready_o  command can be accepted (depends on registered state only)
//   rsp_rdata_o  read data of the response at the FIFO head
//   rsp_err_o    error flag of the response at the FIFO head
//   rsp_valid_o  response valid (FIFO not empty)
//   rsp_ready_i  master accepts the response
// ---------------------------------------------------------------------------
module panda_icb_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_read_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wmask_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  acc_err;

  assign word_idx = cmd_addr_i >> OFF_W;
  assign mem_idx  = word_idx[IDX_W-1:0];

  // With byte-wide data every address is aligned, and there are no offset bits to test.
  generate
    if (OFF_W == 0) begin : g_no_offset
      assign misaligned = 1'b0;
    end else begin : g_offset
      assign misaligned = |cmd_addr_i[OFF_W-1:0];
    end
  endgenerate

  assign out_of_range = (word_idx >= ADDR_WIDTH'(MEM_DEPTH));
  assign acc_err      = misaligned | out_of_range;

  // -------------------------------------------------------------------------
  // Handshakes
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             push;
  logic             pop;

  // Ready comes from the registered count only. When the FIFO is full, a pop
  // on the same edge does not admit a new command; ready returns one cycle
  // later. Ready is also held low for as long as reset is asserted.
  assign cmd_ready_o = ~rst_i & (cnt_q < CNT_W'(RSP_DEPTH));
  assign rsp_valid_o = (cnt_q != '0);

  assign push = cmd_valid_i & cmd_ready_o;
  assign pop  = rsp_valid_o & rsp_ready_i;

  // -------------------------------------------------------------------------
  // Memory array (no reset; contents survive rst_i)
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;

  assign rd_word = mem_q[mem_idx];
  assign mem_we  = push & ~cmd_read_i & ~acc_err;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (cmd_wmask_i[b]) begin
          mem_q[mem_idx][b*8 +: 8] <= cmd_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [RSP_DEPTH];
  logic [RSP_DEPTH-1:0]  fifo_err_q, fifo_err_d;
  logic [DATA_WIDTH-1:0] push_data;

  // Only a legal read carries data. Writes and errored accesses return zero.
  assign push_data = (cmd_read_i & ~acc_err) ? rd_word : '0;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(RSP_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_err_d  = fifo_err_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      fifo_data_d[wptr_q] = push_data;
      fifo_err_d[wptr_q]  = acc_err;
      wptr_d              = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_err_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fifo_err_q  <= fifo_err_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  // While the FIFO is empty, the head outputs are forced to zero. This keeps
  // them at zero during reset and while no response is pending.
  assign rsp_rdata_o = rsp_valid_o ? fifo_data_q[rptr_q] : '0;
  assign rsp_err_o   = rsp_valid_o & fifo_err_q[rptr_q];

endmodule

// File: tb/tb_panda_icb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_panda_icb_sram_slave
//
// Purpose: self-checking bench for panda_icb_sram_slave with default
//   parameters. A behavioural model (a word array plus a queue of expected
//   responses) tracks what the slave must present. The DUT is sampled on the
//   falling edge. Inputs are driven on the falling edge, after the check.
// ---------------------------------------------------------------------------
module tb_panda_icb_sram_slave;

  localparam int DEPTH = 256;
  localparam int RSPD  = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] cmd_addr_i = '0;
  logic        cmd_read_i = 1'b0;
  logic [31:0] cmd_wdata_i = '0;
  logic [3:0]  cmd_wmask_i = '0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  panda_icb_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .RSP_DEPTH(RSPD)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_addr_i(cmd_addr_i), .cmd_read_i(cmd_read_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_wmask_i(cmd_wmask_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] mdl_mem [DEPTH];

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 64'(rsp_valid_o), 64'(exp_q.size() != 0));
    chk({tag, "_ready"}, 64'(cmd_ready_o), 64'(exp_q.size() < RSPD));
    if (exp_q.size() != 0) begin
      chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(exp_q[0].d));
      chk({tag, "_err"},   64'(rsp_err_o),   64'(exp_q[0].e));
    end
  endtask

  // One clock: check what the DUT shows now, then drive the inputs for the
  // coming rising edge, and advance the model to match that edge.
  task automatic cycle(input string tag, input bit v, input bit r, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm, input bit rr);
    bit          acc;
    bit          pop;
    rsp_t        rsp;
    int unsigned idx;
    @(negedge clk_i);
    check_outputs(tag);
    cmd_valid_i = v;
    cmd_read_i  = r;
    cmd_addr_i  = a;
    cmd_wdata_i = wd;
    cmd_wmask_i = wm;
    rsp_ready_i = rr;
    acc = v && (exp_q.size() < RSPD);
    pop = rr && (exp_q.size() != 0);
    if (pop) rsp = exp_q.pop_front();
    if (acc) begin
      idx = a / 4;
      if ((a % 4) != 0 || idx >= DEPTH) begin
        rsp.d = '0;
        rsp.e = 1'b1;
      end else if (r) begin
        rsp.d = mdl_mem[idx];
        rsp.e = 1'b0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (wm[b]) mdl_mem[idx][8*b +: 8] = wd[8*b +: 8];
        rsp.d = '0;
        rsp.e = 1'b0;
      end
      exp_q.push_back(rsp);
    end
  endtask

  task automatic idle(input string tag, input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rr);
  endtask

  initial begin
    // Reset state while rst_i is held high.
    @(posedge clk_i);
    #2;
    chk("rst_valid", 64'(rsp_valid_o), 64'h0);
    chk("rst_ready", 64'(cmd_ready_o), 64'h0);
    chk("rst_rdata", 64'(rsp_rdata_o), 64'h0);
    chk("rst_err",   64'(rsp_err_o),   64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rel_ready", 64'(cmd_ready_o), 64'h1);

    // Give every word a known value. This also exercises back-to-back writes.
    for (int i = 0; i < DEPTH; i++)
      cycle("init", 1'b1, 1'b0, 32'(i * 4), $urandom, 4'hF, 1'b1);
    idle("init_drain", 3, 1'b1);

    // Basic write and read of the same word.
    cycle("wr10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    cycle("rd10", 1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1);
    idle("rd10_drain", 2, 1'b1);
    chk("mdl_beef", 64'(mdl_mem[4]), 64'hDEADBEEF);

    // Partial-mask write merge.
    cycle("wr20a", 1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, 1'b1);
    cycle("wr20b", 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'h5, 1'b1);
    cycle("rd20",  1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1);
    idle("rd20_drain", 2, 1'b1);
    chk("mdl_merge", 64'(mdl_mem[8]), 64'h11BB33DD);

    // Errored accesses: out-of-range read, misaligned write, then word 0 is unchanged.
    cycle("err_oor", 1'b1, 1'b1, 32'h400, 32'h0, 4'h0, 1'b1);
    cycle("err_mis", 1'b1, 1'b0, 32'h02, 32'hFFFFFFFF, 4'hF, 1'b1);
    cycle("rd00",    1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 1'b1);
    idle("err_drain", 2, 1'b1);

    // Backpressure: three reads with rsp_ready low. The third read waits
    // until the cycle after the first pop.
    cycle("bp1", 1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    cycle("bp2", 1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    cycle("bp3", 1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 1'b0);
    cycle("bp3", 1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 1'b0);
    cycle("bp_pop", 1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 1'b1);
    cycle("bp_acc", 1'b1, 1'b1, 32'h00, 32'h0, 4'h0, 1'b1);
    idle("bp_drain", 3, 1'b1);

    // Reset with two responses buffered.
    cycle("pr1", 1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
    cycle("pr2", 1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    @(negedge clk_i);
    check_outputs("pre_rst");
    cmd_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_valid", 64'(rsp_valid_o), 64'h0);
    chk("mid_rst_ready", 64'(cmd_ready_o), 64'h0);
    chk("mid_rst_rdata", 64'(rsp_rdata_o), 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", 64'(cmd_ready_o), 64'h1);
    chk("post_rst_valid", 64'(rsp_valid_o), 64'h0);
    cycle("ret10", 1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1);
    cycle("ret20", 1'b1, 1'b1, 32'h20, 32'h0, 4'h0, 1'b1);
    idle("ret_drain", 2, 1'b1);

    // Streaming: 20 reads with rsp_ready held high, one accepted per cycle.
    for (int i = 0; i < 20; i++)
      cycle("stream", 1'b1, 1'b1, 32'(($urandom % 16) * 4), 32'h0, 4'h0, 1'b1);
    idle("stream_drain", 2, 1'b1);

    // Random mix of reads and writes, with misaligned and out-of-range
    // addresses and random backpressure.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'h400 + 32'($urandom_range(0, 255) * 4);
      else if (kind == 1) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (kind == 2) a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else                a = 32'($urandom_range(0, 15) * 4);
      cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom,
            4'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    idle("final_drain", 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/panda_icb_sram_slave.md
PANDA_ICB_SRAM_SLAVE -- requirements
Module: panda_icb_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the ICB command address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the data width; legal values are 8/16/32/64.
REQ-003 Parameter MEM_DEPTH, default 256, SHALL set the number of DATA_WIDTH-bit words in the memory array.
REQ-004 Parameter RSP_DEPTH, default 2, SHALL set the response-buffer entry count (>=1).
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 cmd_addr  input  ADDR_WIDTH  SHALL be the byte address of the command.
REQ-008 cmd_read  input  1  SHALL select read (1) or write (0).
REQ-009 cmd_wdata  input  DATA_WIDTH  SHALL be the write data.
REQ-010 cmd_wmask  input  DATA_WIDTH/8  SHALL be the per-byte write enables.
REQ-011 cmd_valid  input  1  SHALL mark a valid command.
REQ-012 cmd_ready  output  1  SHALL indicate the command can be accepted.
REQ-013 rsp_rdata  output  DATA_WIDTH  SHALL carry read data.
REQ-014 rsp_err  output  1  SHALL flag an errored access.
REQ-015 rsp_valid  output  1  SHALL mark a valid response.
REQ-016 rsp_ready  input  1  SHALL indicate the master accepts the response.

Function
REQ-017 A command SHALL be accepted on a rising edge where cmd_valid && cmd_ready; a response SHALL pop on an edge where rsp_valid && rsp_ready.
REQ-018 Word index = cmd_addr >> log2(DATA_WIDTH/8); access errors when index >= MEM_DEPTH or the low log2(DATA_WIDTH/8) address bits are nonzero.
REQ-019 Legal write: on the acceptance edge, each byte lane i with cmd_wmask[i]=1 SHALL be updated; other lanes unchanged; response pushed with rsp_rdata=0, rsp_err=0.
REQ-020 Legal read: the memory word SHALL be read combinationally at acceptance and pushed into the response buffer on that edge with rsp_err=0.
REQ-021 Errored access: no memory update; response pushed with rsp_rdata=0, rsp_err=1.
REQ-022 Response latency: a command accepted at edge T SHALL make its response visible at rsp_* from the cycle after T at earliest (rsp_valid high in cycle T+1 if the buffer was empty).
REQ-023 The response buffer SHALL be a FIFO of RSP_DEPTH entries; responses leave in command order.
REQ-024 cmd_ready SHALL equal (count < RSP_DEPTH), registered-state only, with no combinational path from rsp_ready or cmd_valid.
REQ-025 Full: with count == RSP_DEPTH, cmd_ready=0 even if a pop occurs that edge; cmd_ready returns to 1 the cycle after the pop.
REQ-026 Simultaneous push and pop with 0 < count < RSP_DEPTH SHALL leave count unchanged and preserve ordering.
REQ-027 rsp_valid SHALL equal (count != 0); rsp_rdata/rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-028 Read-after-write: a read accepted the edge after a write to the same word SHALL return the written data.
REQ-029 FIFO read/write pointers SHALL wrap modulo RSP_DEPTH without affecting order.

Reset
REQ-030 While rst=1: count=0, pointers=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=0.
REQ-031 First cycle after rst deasserts: cmd_ready=1.
REQ-032 Reset mid-operation SHALL discard all buffered responses immediately; memory contents are not reset and are retained.

Verification
REQ-033 Write 0xDEADBEEF to 0x10, mask 0xF, then read 0x10 -> write rsp err=0 rdata=0; read rsp rdata=0xDEADBEEF err=0, valid the cycle after acceptance.
REQ-034 Write 0x11223344 to 0x20 mask 0xF, then 0xAABBCCDD mask 0x5, read 0x20 -> rdata=0x11BB33DD.
REQ-035 rsp_ready=0, issue 3 back-to-back reads (RSP_DEPTH=2) -> first 2 accepted, cmd_ready=0 in 3rd cycle; raise rsp_ready -> third accepted the cycle after first pop; 3 responses in order.
REQ-036 Read 0x400 (index 256) and write 0x02 -> rsp_err=1, rdata=0, memory word 0 unchanged.
REQ-037 Two commands buffered, assert rst for 1 cycle -> rsp_valid=0 immediately, cmd_ready=1 after release, previously written data still readable.
REQ-038 Continuous cmd_valid and rsp_ready=1 for 20 reads -> one accepted per cycle, steady-state count=1, no loss or reordering.
